// File: rtl/ram_pkg.sv
// Shared widths and requester identity for the dual-port RAM arbiter.
package ram_pkg;

  localparam int D_WIDTH_DEF = 16;
  localparam int A_WIDTH_DEF = 5;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer only moves when the caller
// confirms the grant was actually taken.
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output req_id_t    winner
);

  req_id_t pri;

  always_comb begin
    winner = REQ_0;
    if (req == 2'b11) begin
      winner = pri;
    end else if (req[1]) begin
      winner = REQ_1;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = (winner == REQ_1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri <= REQ_0;
    end else if (advance) begin
      pri <= (winner == REQ_0) ? REQ_1 : REQ_0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one dual-port RAM between two requesters: independent round-robin
// on the write and read ports, with a same-cycle read-after-write stall.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_0,
  input  logic               req_valid_1,
  input  logic               req_we_0,
  input  logic               req_we_1,
  input  logic [A_WIDTH-1:0] req_addr_0,
  input  logic [A_WIDTH-1:0] req_addr_1,
  input  logic [D_WIDTH-1:0] req_wdata_0,
  input  logic [D_WIDTH-1:0] req_wdata_1,
  output logic               req_ready_0,
  output logic               req_ready_1,
  output logic               rsp_valid_0,
  output logic               rsp_valid_1,
  output logic [D_WIDTH-1:0] rsp_data,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  logic [1:0]         w_req;
  logic [1:0]         r_req;
  logic [1:0]         w_grant;
  logic [1:0]         r_cand;
  logic [1:0]         r_grant;
  req_id_t            w_winner;
  req_id_t            r_winner;
  logic               w_any;
  logic               r_any;
  logic               hazard;
  logic [A_WIDTH-1:0] cand_raddr;
  logic [A_WIDTH-1:0] raddr_q;
  logic               rsp_valid_q;
  req_id_t            rsp_id_q;

  // Requests are masked during reset so no ready or RAM strobe can escape.
  assign w_req = {req_valid_1 & req_we_1, req_valid_0 & req_we_0} & {2{~rst}};
  assign r_req = {req_valid_1 & ~req_we_1, req_valid_0 & ~req_we_0} & {2{~rst}};

  rr_arb2 u_write_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_any),
    .grant   (w_grant),
    .winner  (w_winner)
  );

  rr_arb2 u_read_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (r_req),
    .advance (r_any),
    .grant   (r_cand),
    .winner  (r_winner)
  );

  assign w_any             = |w_grant;
  assign ram_write_enable  = w_any;
  assign ram_address_write = (w_winner == REQ_1) ? req_addr_1 : req_addr_0;
  assign ram_data_write    = (w_winner == REQ_1) ? req_wdata_1 : req_wdata_0;

  // A blocked read stalls outright so the pointer stays put and it retries
  // next cycle, when the RAM already holds the freshly written word.
  assign cand_raddr = (r_winner == REQ_1) ? req_addr_1 : req_addr_0;
  assign hazard     = w_any && (cand_raddr == ram_address_write);
  assign r_grant    = hazard ? 2'b00 : r_cand;
  assign r_any      = |r_grant;

  assign req_ready_0 = w_grant[0] | r_grant[0];
  assign req_ready_1 = w_grant[1] | r_grant[1];

  assign ram_address_read = r_any ? cand_raddr : raddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_0;
    end else begin
      if (r_any) begin
        raddr_q <= cand_raddr;
      end
      rsp_valid_q <= r_any;
      rsp_id_q    <= r_winner;
    end
  end

  assign rsp_valid_0 = rsp_valid_q && (rsp_id_q == REQ_0);
  assign rsp_valid_1 = rsp_valid_q && (rsp_id_q == REQ_1);
  assign rsp_data    = rsp_valid_q ? ram_data_read : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural dual-port RAM attached.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic        req_we_0, req_we_1;
  logic [4:0]  req_addr_0, req_addr_1;
  logic [15:0] req_wdata_0, req_wdata_1;
  logic        req_ready_0, req_ready_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [15:0] rsp_data;
  logic        ram_write_enable;
  logic [4:0]  ram_address_write;
  logic [15:0] ram_data_write;
  logic [4:0]  ram_address_read;
  logic [15:0] ram_data_read;

  logic [15:0] mem [0:31];

  int checks;
  int failures;

  ram_arbiter #(.D_WIDTH(16), .A_WIDTH(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_0       (req_valid_0),
    .req_valid_1       (req_valid_1),
    .req_we_0          (req_we_0),
    .req_we_1          (req_we_1),
    .req_addr_0        (req_addr_0),
    .req_addr_1        (req_addr_1),
    .req_wdata_0       (req_wdata_0),
    .req_wdata_1       (req_wdata_1),
    .req_ready_0       (req_ready_0),
    .req_ready_1       (req_ready_1),
    .rsp_valid_0       (rsp_valid_0),
    .rsp_valid_1       (rsp_valid_1),
    .rsp_data          (rsp_data),
    .ram_write_enable  (ram_write_enable),
    .ram_address_write (ram_address_write),
    .ram_data_write    (ram_data_write),
    .ram_address_read  (ram_address_read),
    .ram_data_read     (ram_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM with registered read, both ports on the same clock.
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    ram_data_read <= mem[ram_address_read];
  end

  task automatic idle();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    req_we_0    = 1'b0;
    req_we_1    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd3; req_wdata_0 = 16'h1111;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 5'd4; req_wdata_1 = 16'h0;
    #2;
    checks++; if (req_ready_0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready0 got=%b exp=0", req_ready_0); end
    checks++; if (req_ready_1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready1 got=%b exp=0", req_ready_1); end
    checks++; if (ram_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%b exp=0", ram_write_enable); end
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_rsp_valid got=%b%b exp=00", rsp_valid_1, rsp_valid_0); end
    checks++; if (rsp_data !== 16'h0) begin failures++; $display("[TB] FAIL rst_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if (ram_address_read !== 5'd0) begin failures++; $display("[TB] FAIL rst_addr_read got=%0d exp=0", ram_address_read); end
    #6;
    rst = 1'b0;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin failures++; $display("[TB] FAIL first_grant_ready0 got=%b exp=1", req_ready_0); end
    checks++; if (req_ready_1 !== 1'b1) begin failures++; $display("[TB] FAIL first_grant_ready1 got=%b exp=1", req_ready_1); end
    idle();
    #1;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd3; req_wdata_0 = 16'hBEEF;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin failures++; $display("[TB] FAIL wr_ready0 got=%b exp=1", req_ready_0); end
    checks++; if (ram_write_enable !== 1'b1) begin failures++; $display("[TB] FAIL wr_we got=%b exp=1", ram_write_enable); end
    checks++; if (ram_address_write !== 5'd3) begin failures++; $display("[TB] FAIL wr_addr got=%0d exp=3", ram_address_write); end
    checks++; if (ram_data_write !== 16'hBEEF) begin failures++; $display("[TB] FAIL wr_data got=%h exp=beef", ram_data_write); end
    @(posedge clk); #1;
    req_we_0 = 1'b0;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin failures++; $display("[TB] FAIL rd_ready0 got=%b exp=1", req_ready_0); end
    checks++; if (ram_address_read !== 5'd3) begin failures++; $display("[TB] FAIL rd_addr got=%0d exp=3", ram_address_read); end
    checks++; if (ram_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL rd_no_we got=%b exp=0", ram_write_enable); end
    checks++; if (rsp_valid_0 !== 1'b0) begin failures++; $display("[TB] FAIL rd_early_rsp got=%b exp=0", rsp_valid_0); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (rsp_valid_0 !== 1'b1) begin failures++; $display("[TB] FAIL rd_rsp_valid0 got=%b exp=1", rsp_valid_0); end
    checks++; if (rsp_valid_1 !== 1'b0) begin failures++; $display("[TB] FAIL rd_rsp_valid1 got=%b exp=0", rsp_valid_1); end
    checks++; if (rsp_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL rd_rsp_data got=%h exp=beef", rsp_data); end
    @(posedge clk); #1;
    checks++; if (rsp_valid_0 !== 1'b0) begin failures++; $display("[TB] FAIL rd_rsp_single got=%b exp=0", rsp_valid_0); end
  endtask

  task automatic test_write_rr();
    logic [3:0] exp_win1;
    exp_win1 = 4'b1010;
    do_reset();
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd10; req_wdata_0 = 16'h1010;
    req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 5'd11; req_wdata_1 = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready_1 !== exp_win1[i] || req_ready_0 !== ~exp_win1[i] || ram_write_enable !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrr_grant cycle=%0d got r0=%b r1=%b we=%b exp r0=%b r1=%b we=1",
                 i, req_ready_0, req_ready_1, ram_write_enable, ~exp_win1[i], exp_win1[i]);
      end
      checks++;
      if (ram_address_write !== (exp_win1[i] ? 5'd11 : 5'd10)) begin
        failures++;
        $display("[TB] FAIL wrr_addr cycle=%0d got=%0d exp=%0d", i, ram_address_write, exp_win1[i] ? 11 : 10);
      end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_burst();
    for (int i = 0; i < 3; i++) begin
      req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'(i); req_wdata_0 = 16'h00A0 + 16'(i);
      @(posedge clk); #1;
    end
    req_we_0 = 1'b0; req_addr_0 = 5'd0;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || ram_address_read !== 5'd0) begin failures++; $display("[TB] FAIL burst_first got ready=%b addr=%0d exp ready=1 addr=0", req_ready_0, ram_address_read); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) req_addr_0 = 5'(i + 1);
      else idle();
      #1;
      checks++;
      if (rsp_valid_0 !== 1'b1 || rsp_data !== 16'h00A0 + 16'(i)) begin
        failures++;
        $display("[TB] FAIL burst_rsp idx=%0d got valid=%b data=%h exp valid=1 data=%h", i, rsp_valid_0, rsp_data, 16'h00A0 + 16'(i));
      end
      if (i < 2) begin
        checks++;
        if (req_ready_0 !== 1'b1 || ram_address_read !== 5'(i + 1)) begin
          failures++;
          $display("[TB] FAIL burst_accept idx=%0d got ready=%b addr=%0d exp ready=1 addr=%0d", i + 1, req_ready_0, ram_address_read, i + 1);
        end
      end
    end
    @(posedge clk); #1;
    checks++; if (rsp_valid_0 !== 1'b0) begin failures++; $display("[TB] FAIL burst_end got=%b exp=0", rsp_valid_0); end
  endtask

  task automatic test_parallel();
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd1; req_wdata_0 = 16'h5555;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 5'd2;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b1) begin failures++; $display("[TB] FAIL par_ready got=%b%b exp=11", req_ready_1, req_ready_0); end
    checks++; if (ram_address_write !== 5'd1 || ram_address_read !== 5'd2) begin failures++; $display("[TB] FAIL par_addr got w=%0d r=%0d exp w=1 r=2", ram_address_write, ram_address_read); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0) begin failures++; $display("[TB] FAIL par_rsp_valid got=%b%b exp=10", rsp_valid_1, rsp_valid_0); end
    checks++; if (rsp_data !== 16'h00A2) begin failures++; $display("[TB] FAIL par_rsp_data got=%h exp=00a2", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_hazard();
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd7; req_wdata_0 = 16'h1234;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 5'd7;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin failures++; $display("[TB] FAIL haz_stall got=%b%b exp=01", req_ready_1, req_ready_0); end
    checks++; if (ram_write_enable !== 1'b1) begin failures++; $display("[TB] FAIL haz_we got=%b exp=1", ram_write_enable); end
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    #1;
    checks++; if (req_ready_1 !== 1'b1 || ram_address_read !== 5'd7) begin failures++; $display("[TB] FAIL haz_retry got ready=%b addr=%0d exp ready=1 addr=7", req_ready_1, ram_address_read); end
    checks++; if (rsp_valid_1 !== 1'b0) begin failures++; $display("[TB] FAIL haz_no_rsp got=%b exp=0", rsp_valid_1); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_data !== 16'h1234) begin failures++; $display("[TB] FAIL haz_rsp got valid=%b data=%h exp valid=1 data=1234", rsp_valid_1, rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_rr();
    do_reset();
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 5'd4;
    req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = 5'd5;
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0 || ram_address_read !== 5'd4) begin failures++; $display("[TB] FAIL rrr_first got=%b%b addr=%0d exp=01 addr=4", req_ready_1, req_ready_0, ram_address_read); end
    @(posedge clk); #1;
    req_addr_0 = 5'd6;
    #1;
    checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b1 || ram_address_read !== 5'd5) begin failures++; $display("[TB] FAIL rrr_second got=%b%b addr=%0d exp=10 addr=5", req_ready_1, req_ready_0, ram_address_read); end
    checks++; if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0) begin failures++; $display("[TB] FAIL rrr_rsp got=%b%b exp=01", rsp_valid_1, rsp_valid_0); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0) begin failures++; $display("[TB] FAIL rrr_rsp1 got=%b%b exp=10", rsp_valid_1, rsp_valid_0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 5'd2;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready got=%b exp=1", req_ready_0); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++; if (rsp_valid_0 !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_rsp got=%b exp=1", rsp_valid_0); end
    rst = 1'b1;
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd9; req_wdata_0 = 16'h9999;
    #1;
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_data !== 16'h0) begin failures++; $display("[TB] FAIL mid_rsp_drop got valid=%b data=%h exp valid=0 data=0000", rsp_valid_0, rsp_data); end
    checks++; if (req_ready_0 !== 1'b0 || ram_write_enable !== 1'b0 || ram_address_read !== 5'd0) begin failures++; $display("[TB] FAIL mid_outputs got ready=%b we=%b raddr=%0d exp 0 0 0", req_ready_0, ram_write_enable, ram_address_read); end
    idle();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_release got=%b%b exp=00", rsp_valid_1, rsp_valid_0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    req_addr_0 = '0; req_addr_1 = '0; req_wdata_0 = '0; req_wdata_1 = '0;
    test_reset();
    test_write_read();
    test_write_rr();
    test_burst();
    test_parallel();
    test_hazard();
    test_read_rr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 16: data width, matching the dual-port RAM.
REQ-002 Parameter A_WIDTH, default 5: address width; the RAM depth is 2**A_WIDTH.
REQ-003 clk  in  1  single clock; the integrator drives both RAM clk_write and clk_read from it.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_0 / req_valid_1  in  1 each  requester n has an operation pending.
REQ-006 req_we_0 / req_we_1  in  1 each  1 = write, 0 = read.
REQ-007 req_addr_0 / req_addr_1  in  A_WIDTH each  operation address.
REQ-008 req_wdata_0 / req_wdata_1  in  D_WIDTH each  write data.
REQ-009 req_ready_0 / req_ready_1  out  1 each  operation accepted this cycle.
REQ-010 rsp_valid_0 / rsp_valid_1  out  1 each  read data valid for requester n.
REQ-011 rsp_data  out  D_WIDTH  read data; shared by both requesters, qualified by rsp_valid_n.
REQ-012 ram_write_enable  out  1  to RAM write_enable.
REQ-013 ram_address_write  out  A_WIDTH  to RAM address_write.
REQ-014 ram_data_write  out  D_WIDTH  to RAM data_write.
REQ-015 ram_address_read  out  A_WIDTH  to RAM address_read.
REQ-016 ram_data_read  in  D_WIDTH  from RAM data_read (registered, 1-cycle read).

Function
REQ-017 Per cycle: at most one write grant and at most one read grant; a write and a read may be granted in the same cycle, to the same or different requesters.
REQ-018 Handshake: an operation transfers when req_valid_n && req_ready_n. req_ready_n is combinational from the current requests and arbitration state. Requesters hold valid, we, addr and wdata stable until ready.
REQ-019 Write channel round-robin, 1-bit pointer pri_w (reset 0): if both requesters request a write, requester pri_w wins; after any write grant, pri_w <= ~winner.
REQ-020 Read channel round-robin, separate pointer pri_r (reset 0): same rule as REQ-019.
REQ-021 Write grant: in the same cycle, ram_write_enable=1, ram_address_write=addr and ram_data_write=wdata of the winner. Otherwise ram_write_enable=0.
REQ-022 Read grant: in the same cycle, ram_address_read=addr of the winner. If there is no read grant, ram_address_read holds its last granted value.
REQ-023 Read latency: one cycle. Grant in cycle N gives rsp_valid_n=1 for exactly cycle N+1, with rsp_data=ram_data_read. Responses have no backpressure.
REQ-024 Read-after-write hazard: the read is not granted (ready=0) if the candidate read address equals the address being written in the same cycle. The read is retried next cycle and returns the new data.
REQ-025 A hazard-blocked read does not advance pri_r; the other requester's read is not granted in its place that cycle.
REQ-026 Back-to-back reads are accepted every cycle; reads are not blocked by an outstanding response.
REQ-027 Address wrap: none; all 2**A_WIDTH addresses are valid, and the block performs no address arithmetic.

Reset
REQ-028 While rst=1: req_ready_n=0, rsp_valid_n=0, ram_write_enable=0, rsp_data=0, ram_address_read=0, pri_w=0, pri_r=0.
REQ-029 Asserting rst mid-operation drops any pending response: no rsp_valid after reset release for a read granted before reset.
REQ-030 First grant is possible in the first clock edge after rst deasserts.

Structure
REQ-031 Package ram_pkg holds the D_WIDTH/A_WIDTH defaults and the requester-id type (1 bit).
REQ-032 One sub-module, rr_arb2: 2-input round-robin arbiter with request, grant, pointer and an advance enable. It is instantiated twice (write channel, read channel).
REQ-033 Response tracking is one registered valid bit plus a requester-id register; there is no FIFO.

Verification
REQ-034 Req0 writes addr 3 = 0xBEEF, then reads addr 3 -> ram_write_enable pulse with addr 3; rsp_valid_0 one cycle after read grant; rsp_data=0xBEEF.
REQ-035 Both request write every cycle for 4 cycles (pri_w=0 after reset) -> grants 0,1,0,1; exactly one write per cycle.
REQ-036 Req0 writes addr 7 = 0x1234 while req1 reads addr 7 in the same cycle -> read stalled 1 cycle; rsp_valid_1 with rsp_data=0x1234.
REQ-037 Req0 writes addr 1 while req1 reads addr 2 in the same cycle -> both ready same cycle; rsp_valid_1 next cycle.
REQ-038 Req0 read granted, rst asserted asynchronously before the next edge -> all outputs 0 immediately; no rsp_valid after release.
REQ-039 Req0 issues 3 consecutive reads, addr 0,1,2 (preloaded 0xA0,0xA1,0xA2) -> rsp_valid_0 high for 3 consecutive cycles with data 0xA0, 0xA1, 0xA2.
